retospect_bs_loader: RTL and testbench

Configuration-chain programmer for the neurochip fabric. It accepts a configuration image as a stream of bytes over a valid/ready handshake and serializes it LSB-first onto the fabric's bitstream shift chain. It drives `config_en` for exactly the configured chain length, then issues a one-cycle `reset_nn` pulse so all neurons restart from the fresh configuration. It is the driving end of the chain: its serial output feeds the clock box bitstream input, and the chain tail returns to it.

---
 rtl/retospect_bs_loader.sv | 105 ++++++++++
 tb/tb_retospect_bs_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/retospect_bs_loader.sv
// Streams a byte-wide configuration image LSB-first onto the fabric shift chain, then pulses reset_nn.
// Define RETOSPECT_BS_READBACK_EN to fold the bits leaving the chain tail into a CRC-8 on readback_crc.
module retospect_bs_loader #(
   parameter int CHAIN_LEN = 523,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       cfg_en_o,
   output logic       cfg_bs_o,
   input  logic       cfg_bs_i,
   output logic       nn_rst_o,
   output logic       busy,
   output logic       done,
   output logic [7:0] readback_crc
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      NNRST = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

   state_t           state;
   logic [7:0]       shreg;
   logic [CNT_W-1:0] bitcnt;

   // Byte boundaries fall on multiples of 8 in bitcnt, so its low bits track the bit within the byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         shreg  <= '0;
         bitcnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= LOAD;
                  shreg  <= '0;
                  bitcnt <= '0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  shreg <= in_data;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               shreg  <= {1'b0, shreg[7:1]};
               bitcnt <= bitcnt + CNT_W'(1);
               if (bitcnt == LAST_BIT) begin
                  state <= NNRST;
               end else if (bitcnt[2:0] == 3'd7) begin
                  state <= LOAD;
               end
            end
            NNRST:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == LOAD);
   assign cfg_en_o = (state == SHIFT);
   assign cfg_bs_o = (state == SHIFT) && shreg[0];
   assign nn_rst_o = (state == NNRST);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

`ifdef RETOSPECT_BS_READBACK_EN
   logic [7:0] crc;
   logic       crc_fb;

   assign crc_fb = crc[7] ^ cfg_bs_i;

   // The tail bit is sampled before the edge that shifts the chain, so it is the bit leaving the fabric.
   always_ff @(posedge clk) begin
      if (reset) begin
         crc <= 8'h00;
      end else if ((state == IDLE) && start) begin
         crc <= 8'h00;
      end else if (state == SHIFT) begin
         crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
      end
   end

   assign readback_crc = crc;
`else
   logic unused_bs_i;

   assign unused_bs_i  = cfg_bs_i;
   assign readback_crc = 8'h00;
`endif

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench for retospect_bs_loader with a 12-bit chain model looped back into cfg_bs_i.
// Readback expectations follow RETOSPECT_BS_READBACK_EN when it is defined for the build.
module tb_retospect_bs_loader;

   localparam int L = 12;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         cfg_en_o;
   logic         cfg_bs_o;
   logic         cfg_bs_i;
   logic         nn_rst_o;
   logic         busy;
   logic         done;
   logic [7:0]   readback_crc;

   logic [L-1:0] chain = '0;
   logic [L-1:0] chainBefore;
   logic [L-1:0] bitsOut;
   logic [7:0]   expCrc;

   int total = 0;
   int bad   = 0;
   int enCount, hsCount, shiftsAtHs2, nnCount, doneCount, stallEn, postBusy;
   int lastEnCycle, nnCycle, doneCycle;
   bit doneSeen;

   always #5 clk = ~clk;

   // Fabric chain: new bits enter at the head, the first bit shifted ends at chain[0] (the tail).
   always @(posedge clk) begin
      if (cfg_en_o) chain <= {cfg_bs_o, chain[L-1:1]};
   end

   assign cfg_bs_i = chain[0];

   retospect_bs_loader #(.CHAIN_LEN(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .cfg_en_o     (cfg_en_o),
      .cfg_bs_o     (cfg_bs_o),
      .cfg_bs_i     (cfg_bs_i),
      .nn_rst_o     (nn_rst_o),
      .busy         (busy),
      .done         (done),
      .readback_crc (readback_crc)
   );

   function automatic logic [7:0] crcModel(input logic [L-1:0] bits);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 0; i < L; i++) begin
         fb = c[7] ^ bits[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one complete load of a two-byte image and records what the loader did on every cycle.
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                                input bit poke, input bit holdValid);
      int         idx;
      int         stallLeft;
      logic       hs;
      logic [7:0] img [2];
      img[0] = b0;
      img[1] = b1;
      idx = 0;
      stallLeft = stall;
      enCount = 0; hsCount = 0; shiftsAtHs2 = -1; nnCount = 0; doneCount = 0;
      stallEn = 0; postBusy = 0; bitsOut = '0; doneSeen = 0;
      lastEnCycle = -1; nnCycle = -1; doneCycle = -1;
      chainBefore = chain;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 60 && !doneSeen; c++) begin
         start = 1'b0;
         if (idx < 2) begin
            in_data  = img[idx];
            in_valid = 1'b1;
         end else begin
            in_data  = 8'hFF;
            in_valid = holdValid;
         end
         if (in_ready && idx == 1 && stallLeft > 0) begin
            in_valid = 1'b0;
            stallLeft--;
            if (cfg_en_o) stallEn++;
         end
         if (poke && cfg_en_o && enCount == 3) start = 1'b1;
         hs = in_valid && in_ready;
         tick;
         if (hs) begin
            idx++;
            hsCount++;
            if (idx == 2) shiftsAtHs2 = enCount;
         end
         if (cfg_en_o) begin
            if (enCount < L) bitsOut[enCount] = cfg_bs_o;
            enCount++;
            lastEnCycle = c;
         end
         if (nn_rst_o) begin
            nnCount++;
            nnCycle = c;
         end
         if (done) begin
            doneCount++;
            doneCycle = c;
            doneSeen = 1'b1;
         end
      end
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         hs = in_valid && in_ready;
         tick;
         if (hs) hsCount++;
         if (nn_rst_o) nnCount++;
         if (done) doneCount++;
         if (busy) postBusy++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      tick;
      tick;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_cfg_en", cfg_en_o, 1'b0);
      checkOutput("rst_cfg_bs", cfg_bs_o, 1'b0);
      checkOutput("rst_nn_rst", nn_rst_o, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_crc", readback_crc, 8'h00);
      start = 1'b0;
      reset = 1'b0;
      tick;
      checkOutput("idle_busy", busy, 1'b0);

      $display("[TB] image A = A5 03, continuous valid");
      applyStimulus(8'hA5, 8'h03, 0, 1'b0, 1'b0);
      checkOutput("A_done_seen", doneSeen, 1'b1);
      checkOutput("A_bits", bitsOut, 12'b0011_1010_0101);
      checkOutput("A_en_cycles", enCount, L);
      checkOutput("A_bytes", hsCount, 2);
      checkOutput("A_hs2_after", shiftsAtHs2, 8);
      checkOutput("A_nn_pulses", nnCount, 1);
      checkOutput("A_done_pulses", doneCount, 1);
      checkOutput("A_nn_after_shift", nnCycle - lastEnCycle, 1);
      checkOutput("A_done_after_nn", doneCycle - nnCycle, 1);
      checkOutput("A_busy_after", postBusy, 0);
      checkOutput("A_chain", chain, 12'h3A5);
`ifdef RETOSPECT_BS_READBACK_EN
      expCrc = crcModel(chainBefore);
`else
      expCrc = 8'h00;
`endif
      checkOutput("A_crc", readback_crc, expCrc);

      $display("[TB] image B = 3C 0A, stalls, start during SHIFT, valid held after");
      applyStimulus(8'h3C, 8'h0A, 4, 1'b1, 1'b1);
      checkOutput("B_done_seen", doneSeen, 1'b1);
      checkOutput("B_bits", bitsOut, 12'hA3C);
      checkOutput("B_stall_en", stallEn, 0);
      checkOutput("B_en_cycles", enCount, L);
      checkOutput("B_bytes", hsCount, 2);
      checkOutput("B_nn_pulses", nnCount, 1);
      checkOutput("B_done_pulses", doneCount, 1);
      checkOutput("B_busy_after", postBusy, 0);
      checkOutput("B_chain", chain, 12'hA3C);
`ifdef RETOSPECT_BS_READBACK_EN
      expCrc = crcModel(12'h3A5);
`else
      expCrc = 8'h00;
`endif
      checkOutput("B_crc_is_A", readback_crc, expCrc);

      $display("[TB] reset in the 5th SHIFT cycle");
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h5A;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      tick;
      tick;
      checkOutput("R_in_shift", cfg_en_o, 1'b1);
      reset = 1'b1;
      tick;
      checkOutput("R_busy", busy, 1'b0);
      checkOutput("R_cfg_en", cfg_en_o, 1'b0);
      checkOutput("R_nn_rst", nn_rst_o, 1'b0);
      reset = 1'b0;
      nnCount = 0;
      doneCount = 0;
      for (int c = 0; c < 4; c++) begin
         tick;
         if (nn_rst_o) nnCount++;
         if (done) doneCount++;
      end
      checkOutput("R_nn_never", nnCount, 0);
      checkOutput("R_done_never", doneCount, 0);

      $display("[TB] image C = F0 05 after aborted load");
      applyStimulus(8'hF0, 8'h05, 0, 1'b0, 1'b0);
      checkOutput("C_done_seen", doneSeen, 1'b1);
      checkOutput("C_en_cycles", enCount, L);
      checkOutput("C_chain", chain, 12'h5F0);
`ifdef RETOSPECT_BS_READBACK_EN
      expCrc = crcModel(chainBefore);
`else
      expCrc = 8'h00;
`endif
      checkOutput("C_crc", readback_crc, expCrc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
